mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback datapath of the 5-stage CPU.
- Captures MEM-stage results on the rising clock edge.
- Extracts and extends load data, selects the writeback value, and drives the register file write port (RFWr, A3, WD). The register file writes on the falling edge.
- Also maintains a retired-instruction counter for performance monitoring.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- stall  in  1  hold current WB contents.
- flush  in  1  replace incoming entry with a bubble.
- m_valid  in  1  MEM stage holds a real instruction.
- m_regwrite  in  1  instruction writes rd.
- m_wdsel  in  2  writeback source: 0 ALU, 1 load data, 2 PC+4, 3 reserved.
- m_dmtype  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others decoded as lw.
- m_rd  in  5  destination register.
- m_alu_out  in  32  ALU result / effective address.
- m_rdata  in  32  raw aligned word from data memory.
- m_pc  in  32  instruction PC.
- RFWr  out  1  register file write enable.
- A3  out  5  register file write address.
- WD  out  32  register file write data.
- wb_valid  out  1  WB holds a real instruction.
- wb_pc  out  32  PC of instruction in WB.
- retire_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers clear; wb_valid=0, RFWr=0, A3=0, WD=0, wb_pc=0, retire_cnt=0. Reset deasserting mid-operation leaves an empty stage; the first capture happens on the next rising edge.
- Register update at posedge clk, priority order:
  1. flush=1: load a bubble (valid=0, regwrite=0, all other fields 0). Flush beats stall.
  2. stall=1: hold all registers unchanged.
  3. Otherwise: capture all m_* inputs.
- Latency: one cycle from MEM inputs to RFWr/A3/WD. Outputs are combinational from the WB registers only; there are no input-to-output combinational paths.
- RFWr = wb_valid & regwrite_q & (rd_q != 0). A3 = rd_q.
- Load extraction uses off = alu_out_q[1:0]:
  - lw: whole word; off ignored.
  - lh / lhu: half = off[1] ? rdata[31:16] : rdata[15:0]; sign- or zero-extended.
  - lb / lbu: byte lane selected by off (0 → [7:0] … 3 → [31:24]); sign- or zero-extended.
- WD selection:
  - wdsel 0: alu_out_q.
  - wdsel 1: extracted load data.
  - wdsel 2: pc_q + 4, mod 2^32 (0xFFFFFFFC → 0x00000000).
  - wdsel 3: 0.
- WD is valid for the whole cycle, so it is stable before the register file's falling-edge write and for its same-cycle read bypass.
- While stalled, RFWr stays asserted for a held write. The repeated write of an identical value is permitted and harmless.
- retire_cnt increments by 1 at a posedge where wb_valid=1 and stall=0, i.e. the instruction leaves WB. The increment occurs even when flush=1 in that cycle, because the leaving entry has already completed. Bubbles never count. The counter wraps from all-ones to 0.
- wb_pc = pc_q; it is held while stalled and cleared by flush.

Test Plan:
- Reset then ALU op: m_valid=1, regwrite=1, wdsel=0, rd=5, alu_out=0x1234_5678 → next cycle RFWr=1, A3=5, WD=0x12345678; retire_cnt becomes 1 one edge later.
- Loads with rdata=0x80F1_7F82:
  - lb off=0 → 0xFFFFFF82.
  - lbu off=0 → 0x00000082.
  - lb off=1 → 0x0000007F.
  - lh off=2 → 0xFFFF80F1.
  - lhu off=2 → 0x000080F1.
  - lw off=3 → 0x80F17F82.
- rd=0 with regwrite=1 → RFWr=0; instruction still counts as retired.
- Jal writeback: wdsel=2, pc=0x0000_0100 → WD=0x00000104; pc=0xFFFF_FFFC → WD=0x00000000.
- Stall 3 cycles with a valid entry in WB:
  - A3/WD/wb_pc held and RFWr stays 1.
  - retire_cnt unchanged until stall drops, then +1.
  - flush and stall together → bubble: wb_valid=0, RFWr=0.
- Assert rst=0 asynchronously mid-cycle with a valid entry and retire_cnt=7 → all outputs 0 immediately, before any clock edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, writeback select and a
// retired-instruction counter. Outputs depend only on the WB registers.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             m_valid,
  input  logic             m_regwrite,
  input  logic [1:0]       m_wdsel,
  input  logic [2:0]       m_dmtype,
  input  logic [4:0]       m_rd,
  input  logic [31:0]      m_alu_out,
  input  logic [31:0]      m_rdata,
  input  logic [31:0]      m_pc,
  output logic             RFWr,
  output logic [4:0]       A3,
  output logic [31:0]      WD,
  output logic             wb_valid,
  output logic [31:0]      wb_pc,
  output logic [CNT_W-1:0] retire_cnt
);

  logic             r_valid;
  logic             r_regwrite;
  logic [1:0]       r_wdsel;
  logic [2:0]       r_dmtype;
  logic [4:0]       r_rd;
  logic [31:0]      r_alu_out;
  logic [31:0]      r_rdata;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_retire_cnt;

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_wdsel    <= 2'd0;
      r_dmtype   <= 3'd0;
      r_rd       <= 5'd0;
      r_alu_out  <= 32'd0;
      r_rdata    <= 32'd0;
      r_pc       <= 32'd0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_wdsel    <= 2'd0;
      r_dmtype   <= 3'd0;
      r_rd       <= 5'd0;
      r_alu_out  <= 32'd0;
      r_rdata    <= 32'd0;
      r_pc       <= 32'd0;
    end else if (!stall) begin
      r_valid    <= m_valid;
      r_regwrite <= m_regwrite;
      r_wdsel    <= m_wdsel;
      r_dmtype   <= m_dmtype;
      r_rd       <= m_rd;
      r_alu_out  <= m_alu_out;
      r_rdata    <= m_rdata;
      r_pc       <= m_pc;
    end
  end

  // The leaving entry has completed even when a flush replaces it, so only stall blocks the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire_cnt <= '0;
    end else if (r_valid && !stall) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = r_rdata[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_lane[r_alu_out[1:0]];
  assign w_half = r_alu_out[1] ? r_rdata[31:16] : r_rdata[15:0];

  always_comb begin
    w_load = r_rdata;
    case (r_dmtype)
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = {16'd0, w_half};
      3'b011:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      default: w_load = r_rdata;
    endcase
  end

  always_comb begin
    w_wd = 32'd0;
    case (r_wdsel)
      2'd0:    w_wd = r_alu_out;
      2'd1:    w_wd = w_load;
      2'd2:    w_wd = r_pc + 32'd4;
      default: w_wd = 32'd0;
    endcase
  end

  assign RFWr       = r_valid & r_regwrite & (r_rd != 5'd0);
  assign A3         = r_rd;
  assign WD         = w_wd;
  assign wb_valid   = r_valid;
  assign wb_pc      = r_pc;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: loads, writeback select, stall/flush,
// retire counting and asynchronous reset, with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_regwrite = 1'b0;
  logic [1:0]  m_wdsel = 2'd0;
  logic [2:0]  m_dmtype = 3'd0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_alu_out = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] m_pc = 32'd0;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_regwrite(m_regwrite), .m_wdsel(m_wdsel),
    .m_dmtype(m_dmtype), .m_rd(m_rd), .m_alu_out(m_alu_out),
    .m_rdata(m_rdata), .m_pc(m_pc),
    .RFWr(RFWr), .A3(A3), .WD(WD), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one MEM-stage entry, then let one rising edge capture it.
  task automatic issue(input logic st, input logic fl, input logic v, input logic rw,
                       input logic [1:0] ws, input logic [2:0] dt, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc);
    stall = st; flush = fl; m_valid = v; m_regwrite = rw; m_wdsel = ws;
    m_dmtype = dt; m_rd = rd; m_alu_out = alu; m_rdata = rdata; m_pc = pc;
    @(posedge clk);
    #1;
    $display("t=%0t stall=%0b flush=%0b v=%0b rd=%0d -> RFWr=%0b A3=%0d WD=%08h wb_valid=%0b wb_pc=%08h cnt=%0d",
             $time, st, fl, v, rd, RFWr, A3, WD, wb_valid, wb_pc, retire_cnt);
  endtask

  task automatic chk_wb(input string tag, input logic rfwr, input logic [4:0] a3,
                        input logic [31:0] wd, input logic vld, input logic [31:0] cnt);
    chk({tag, ".RFWr"}, 32'(RFWr), 32'(rfwr));
    chk({tag, ".A3"}, 32'(A3), 32'(a3));
    chk({tag, ".WD"}, WD, wd);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(vld));
    chk({tag, ".cnt"}, retire_cnt, cnt);
  endtask

  localparam logic [31:0] RDAT = 32'h80F1_7F82;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_wb("reset", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    chk("reset.wb_pc", wb_pc, 32'd0);
    rst = 1'b1;

    issue(0, 0, 1, 1, 2'd0, 3'd0, 5'd5, 32'h1234_5678, 32'd0, 32'h0000_0010);
    chk_wb("alu", 1'b1, 5'd5, 32'h1234_5678, 1'b1, 32'd0);
    chk("alu.wb_pc", wb_pc, 32'h0000_0010);
    issue(0, 0, 1, 1, 2'd1, 3'b011, 5'd6, 32'h1000_0000, RDAT, 32'h14);
    chk_wb("lb0", 1'b1, 5'd6, 32'hFFFF_FF82, 1'b1, 32'd1);
    issue(0, 0, 1, 1, 2'd1, 3'b100, 5'd6, 32'h1000_0000, RDAT, 32'h18);
    chk_wb("lbu0", 1'b1, 5'd6, 32'h0000_0082, 1'b1, 32'd2);
    issue(0, 0, 1, 1, 2'd1, 3'b011, 5'd6, 32'h1000_0001, RDAT, 32'h1C);
    chk_wb("lb1", 1'b1, 5'd6, 32'h0000_007F, 1'b1, 32'd3);
    issue(0, 0, 1, 1, 2'd1, 3'b001, 5'd6, 32'h1000_0002, RDAT, 32'h20);
    chk_wb("lh2", 1'b1, 5'd6, 32'hFFFF_80F1, 1'b1, 32'd4);
    issue(0, 0, 1, 1, 2'd1, 3'b010, 5'd6, 32'h1000_0002, RDAT, 32'h24);
    chk_wb("lhu2", 1'b1, 5'd6, 32'h0000_80F1, 1'b1, 32'd5);
    issue(0, 0, 1, 1, 2'd1, 3'b000, 5'd6, 32'h1000_0003, RDAT, 32'h28);
    chk_wb("lw3", 1'b1, 5'd6, RDAT, 1'b1, 32'd6);
    issue(0, 0, 1, 1, 2'd2, 3'd0, 5'd1, 32'd0, 32'd0, 32'h0000_0100);
    chk_wb("jal", 1'b1, 5'd1, 32'h0000_0104, 1'b1, 32'd7);

    // Reset in the middle of a cycle must clear everything without a clock edge.
    #3 rst = 1'b0;
    #1;
    chk_wb("async_rst", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    chk("async_rst.wb_pc", wb_pc, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst_release.wb_valid", 32'(wb_valid), 32'd0);

    issue(0, 0, 1, 1, 2'd2, 3'd0, 5'd1, 32'd0, 32'd0, 32'hFFFF_FFFC);
    chk_wb("jal_wrap", 1'b1, 5'd1, 32'h0000_0000, 1'b1, 32'd0);
    chk("jal_wrap.wb_pc", wb_pc, 32'hFFFF_FFFC);
    issue(0, 0, 1, 1, 2'd0, 3'd0, 5'd0, 32'h0000_ABCD, 32'd0, 32'h30);
    chk_wb("rd0", 1'b0, 5'd0, 32'h0000_ABCD, 1'b1, 32'd1);
    issue(0, 0, 0, 0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    chk_wb("bubble", 1'b0, 5'd0, 32'd0, 1'b0, 32'd2);
    issue(0, 0, 1, 1, 2'd0, 3'd0, 5'd7, 32'hDEAD_BEEF, 32'd0, 32'h0000_0200);
    chk_wb("pre_stall", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 32'd2);

    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 1, 1, 2'd0, 3'd0, 5'd9, 32'h0000_1111, 32'd0, 32'h0000_0300);
      chk_wb($sformatf("stall%0d", i), 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 32'd2);
      chk($sformatf("stall%0d.wb_pc", i), wb_pc, 32'h0000_0200);
    end

    issue(0, 0, 1, 1, 2'd0, 3'd0, 5'd8, 32'h0000_0055, 32'd0, 32'h0000_0204);
    chk_wb("unstall", 1'b1, 5'd8, 32'h0000_0055, 1'b1, 32'd3);
    issue(1, 1, 1, 1, 2'd0, 3'd0, 5'd9, 32'h0000_1111, 32'd0, 32'h0000_0300);
    chk_wb("flush_stall", 1'b0, 5'd0, 32'd0, 1'b0, 32'd3);
    chk("flush_stall.wb_pc", wb_pc, 32'd0);
    issue(0, 0, 1, 1, 2'd3, 3'd0, 5'd3, 32'h0000_0077, 32'd0, 32'h0000_0400);
    chk_wb("wdsel3", 1'b1, 5'd3, 32'd0, 1'b1, 32'd3);
    issue(0, 1, 1, 1, 2'd0, 3'd0, 5'd4, 32'h0000_0099, 32'd0, 32'h0000_0404);
    chk_wb("flush", 1'b0, 5'd0, 32'd0, 1'b0, 32'd4);
    issue(0, 0, 0, 0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    chk_wb("idle", 1'b0, 5'd0, 32'd0, 1'b0, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
